// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared DW-bit register.
// Requesters win a one-cycle grant in IDLE; the winner's data is committed at the GRANT closing edge.
module shared_reg_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IW   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic             clr,
  output logic [NREQ-1:0]  gnt,
  output logic [DW-1:0]    q,
  output logic             q_valid,
  output logic [IW-1:0]    owner,
  output logic             done,
  output logic             abort,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Handshake: req[i] must stay high (with its wdata slice stable) through the
  // cycle gnt[i] is high; dropping it there aborts, keeping it commits.

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [NREQ-1:0] gnt_q;
  logic [DW-1:0]   data_q;
  logic            valid_q;
  logic [IW-1:0]   owner_q;
  logic            done_q;
  logic            abort_q;

  logic [IW-1:0]   pick_hi_d;
  logic [IW-1:0]   pick_lo_d;
  logic            any_hi_d;
  logic            any_lo_d;
  logic [IW-1:0]   pick_d;
  logic [IW-1:0]   ptr_next_d;

  // Two-pass scan: first set bit at or above the pointer, else the lowest set bit (wrap).
  always_comb begin
    pick_hi_d = '0;
    pick_lo_d = '0;
    any_hi_d  = 1'b0;
    any_lo_d  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_hi_d && req[i] && (i >= int'(ptr_q))) begin
        any_hi_d  = 1'b1;
        pick_hi_d = IW'(i);
      end
      if (!any_lo_d && req[i]) begin
        any_lo_d  = 1'b1;
        pick_lo_d = IW'(i);
      end
    end
    pick_d = any_hi_d ? pick_hi_d : pick_lo_d;
  end

  assign ptr_next_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr) begin
            data_q  <= '0;
            valid_q <= 1'b0;
          end else if (any_lo_d) begin
            gnt_q   <= NREQ'(1) << pick_d;
            win_q   <= pick_d;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          gnt_q   <= '0;
          state_q <= IDLE;
          if (clr) begin
            data_q  <= '0;
            valid_q <= 1'b0;
          end else if (req[win_q]) begin
            data_q  <= wdata[win_q*DW +: DW];
            valid_q <= 1'b1;
            owner_q <= win_q;
            done_q  <= 1'b1;
            ptr_q   <= ptr_next_d;
            state_q <= COMMIT;
          end else begin
            abort_q <= 1'b1;
            ptr_q   <= ptr_next_d;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign q         = data_q;
  assign q_valid   = valid_q;
  assign owner     = owner_q;
  assign done      = done_q;
  assign abort     = abort_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: scenario tasks plus randomized transactions checked
// against a transaction-level round-robin model (pointer, register value, owner).
module tb_shared_reg_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] wdata;
  logic              clr;
  logic [NREQ-1:0]   gnt;
  logic [DW-1:0]     q;
  logic              q_valid;
  logic [IW-1:0]     owner;
  logic              done;
  logic              abort;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         ptr_m   = 0;
  logic [7:0] q_m     = '0;
  logic       qv_m    = 1'b0;
  int         owner_m = 0;

  shared_reg_arbiter #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata), .clr(clr),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .done(done),
    .abort(abort), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_pick(input logic [3:0] r);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m = 0; q_m = '0; qv_m = 1'b0; owner_m = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req = '0; wdata = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  // One arbitration from IDLE; mode 0 = commit, 1 = winner drops req, 2 = clr during GRANT.
  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_txn(input logic [3:0] r, input logic [31:0] wd, input int mode);
    int w;
    logic [3:0] exp_g;
    req = r; wdata = wd; clr = 1'b0;
    w = model_pick(r);
    exp_g = (w < 0) ? 4'b0000 : 4'(1 << w);
    @(negedge clk);
    checks++; if (gnt !== exp_g) begin errors++; $display("FAIL grant: got %b expected %b", gnt, exp_g); end
    checks++; if (done !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL grant_pulses: done %b abort %b expected 0 0", done, abort); end
    if (w < 0) return;
    if (mode == 1) req[w] = 1'b0;
    if (mode == 2) clr = 1'b1;
    for (int i = 0; i < NREQ; i++)
      if (i != w) wdata[i*8 +: 8] = 8'($urandom);
    @(negedge clk);
    if (mode == 0) begin
      q_m = wd[w*8 +: 8]; qv_m = 1'b1; owner_m = w; ptr_m = (w + 1) % NREQ;
      checks++; if (done !== 1'b1 || abort !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL commit_flags: done %b abort %b gnt %b expected 1 0 0000", done, abort, gnt); end
      checks++; if (q !== q_m || q_valid !== 1'b1) begin errors++; $display("FAIL commit_data: q %h valid %b expected %h 1", q, q_valid, q_m); end
      checks++; if (owner !== IW'(owner_m)) begin errors++; $display("FAIL commit_owner: got %0d expected %0d", owner, owner_m); end
      // Inputs wiggled during COMMIT, including clr, must not disturb anything.
      wdata = $urandom; req = 4'($urandom); clr = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (done !== 1'b0 || gnt !== 4'b0000 || abort !== 1'b0) begin errors++; $display("FAIL post_commit: done %b gnt %b abort %b expected 0 0000 0", done, gnt, abort); end
      checks++; if (q !== q_m || q_valid !== qv_m) begin errors++; $display("FAIL post_commit_q: q %h valid %b expected %h %b", q, q_valid, q_m, qv_m); end
    end else if (mode == 1) begin
      ptr_m = (w + 1) % NREQ;
      checks++; if (abort !== 1'b1 || done !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL abort_flags: abort %b done %b gnt %b expected 1 0 0000", abort, done, gnt); end
      checks++; if (q !== q_m || q_valid !== qv_m) begin errors++; $display("FAIL abort_q: q %h valid %b expected %h %b", q, q_valid, q_m, qv_m); end
    end else begin
      q_m = '0; qv_m = 1'b0;
      checks++; if (gnt !== 4'b0000 || done !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL clr_grant_flags: gnt %b done %b abort %b expected 0000 0 0", gnt, done, abort); end
      checks++; if (q !== 8'h00 || q_valid !== 1'b0) begin errors++; $display("FAIL clr_grant_q: q %h valid %b expected 00 0", q, q_valid); end
    end
    req = '0; clr = 1'b0;
  endtask

  task automatic clr_idle(input logic [3:0] r);
    req = r; clr = 1'b1;
    @(negedge clk);
    q_m = '0; qv_m = 1'b0;
    checks++; if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0) begin errors++; $display("FAIL clr_idle: gnt %b q %h valid %b expected 0000 00 0", gnt, q, q_valid); end
    req = '0; clr = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0) begin errors++; $display("FAIL reset_regs: gnt %b q %h valid %b expected 0000 00 0", gnt, q, q_valid); end
    checks++; if (owner !== 2'd0 || done !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL reset_flags: owner %0d done %b abort %b expected 0 0 0", owner, done, abort); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || done !== 1'b0) begin errors++; $display("FAIL reset_idle: gnt %b done %b expected 0000 0", gnt, done); end
  endtask

  task automatic test_single();
    run_txn(4'b0100, 32'h00A5_0000, 0);
    checks++; if (q !== 8'hA5 || owner !== 2'd2) begin errors++; $display("FAIL single: q %h owner %0d expected a5 2", q, owner); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 32'h1312_1110, 0);
      checks++; if (owner !== IW'(i % 4) || q !== 8'(8'h10 + (i % 4))) begin errors++; $display("FAIL rr_order: owner %0d q %h expected %0d %h", owner, q, i % 4, 8'h10 + (i % 4)); end
    end
  endtask

  task automatic test_wrap();
    run_txn(4'b1000, 32'h3300_0000, 0);
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL wrap_first: owner %0d expected 3", owner); end
    run_txn(4'b1001, 32'h3900_0090, 0);
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL wrap_second: owner %0d expected 0", owner); end
    run_txn(4'b1001, 32'h3A00_00A0, 0);
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL wrap_third: owner %0d expected 3", owner); end
  endtask

  task automatic test_abort();
    run_txn(4'b0010, 32'h0000_7700, 1);
    run_txn(4'b0011, 32'h0000_6655, 0);
    checks++; if (owner !== 2'd0 || q !== 8'h55) begin errors++; $display("FAIL abort_next: owner %0d q %h expected 0 55", owner, q); end
  endtask

  task automatic test_clear();
    run_txn(4'b0001, 32'h0000_005A, 0);
    clr_idle(4'b0001);
    run_txn(4'b0010, 32'h0000_2200, 2);
    run_txn(4'b0010, 32'h0000_2300, 0);
    checks++; if (owner !== 2'd1 || q !== 8'h23) begin errors++; $display("FAIL clr_rewin: owner %0d q %h expected 1 23", owner, q); end
  endtask

  task automatic test_async_reset();
    run_txn(4'b0001, 32'h0000_0011, 0);
    req = 4'b1000; wdata = 32'h4400_0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL areset_pre: gnt %b expected 1000", gnt); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0 || done !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL areset_now: gnt %b q %h valid %b done %b abort %b expected all 0", gnt, q, q_valid, done, abort); end
    model_reset();
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(4'b1001, 32'h4400_0033, 0);
    checks++; if (owner !== 2'd0 || q !== 8'h33) begin errors++; $display("FAIL areset_ptr: owner %0d q %h expected 0 33", owner, q); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int roll;
      roll = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) clr_idle(4'($urandom_range(0, 15)));
      run_txn(4'($urandom_range(1, 15)), $urandom, (roll < 7) ? 0 : (roll < 9) ? 1 : 2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_abort();
    test_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter and write sequencer for one shared DW-bit register built from asynchronously reset D flip-flops. Up to NREQ requesters compete to load the register through a registered req/gnt handshake. A synchronous clear path is also provided. The block sits between producer blocks and the shared state register they all update.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, width of the shared register and of each requester's data slice
IW, 2, width of owner index; must equal ceil(log2(NREQ))

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous reset, active low
req  input  NREQ  request per requester; bit i is requester i
wdata  input  NREQ*DW  requester i data on bits [i*DW +: DW]
clr  input  1  synchronous clear request for the shared register
gnt  output  NREQ  one-hot grant, registered
q  output  DW  shared register contents
q_valid  output  1  high once q holds a committed write; low after reset or clear
owner  output  IW  index of the requester that last wrote q
done  output  1  one-cycle pulse: write committed this cycle
abort  output  1  one-cycle pulse: granted requester dropped req during GRANT

Behaviour:
- Reset (reset_n=0, any time, asynchronous), all of the following:
  - state=IDLE, gnt=0, q=0, q_valid=0, owner=0, done=0, abort=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
- FSM states: IDLE, GRANT, COMMIT. All outputs are registered.
- IDLE:
  - If clr=1: q<=0, q_valid<=0, stay IDLE. clr beats req.
  - Else if req!=0: pick the first set bit scanning from the pointer upward with wrap (pointer, pointer+1, ..., NREQ-1, 0, ...). Set gnt<=onehot(winner), latch winner index, go to GRANT.
  - Else stay IDLE.
- GRANT: gnt stays high for exactly one cycle. At the closing edge:
  - If clr=1: gnt<=0, q<=0, q_valid<=0, go to IDLE. Pointer is unchanged; no done or abort.
  - Else if req[winner]=1: q<=wdata slice of winner, q_valid<=1, owner<=winner, done<=1, gnt<=0, pointer<=(winner+1) mod NREQ, go to COMMIT.
  - Else: gnt<=0, abort<=1, pointer<=(winner+1) mod NREQ, q unchanged, go to IDLE.
- COMMIT: lasts one cycle. done=1 during it. Always go to IDLE; done<=0. clr in COMMIT is ignored and is handled on the next IDLE cycle.
- abort is high for the single IDLE cycle that follows GRANT.
- Latency:
  - req rising to gnt high: 1 cycle.
  - gnt to q update: 1 cycle (q changes on the same edge that asserts done).
  - Maximum throughput: one write per 3 cycles.
- Requester rules:
  - Hold req and wdata stable through the GRANT cycle.
  - Data is sampled only at the GRANT closing edge.
  - Changes to wdata outside that edge do not affect q.
- Requests from non-winners are ignored until the next IDLE arbitration; nothing is queued internally.
- Pointer wraps from NREQ-1 to 0.
- gnt is never multi-hot and is 0 in IDLE and COMMIT.
- Reset mid-GRANT or mid-COMMIT: immediate return to reset values; no partial write survives.

Test Plan:
- Reset then single request: reset_n low 3 cycles, release; req=4'b0100, wdata slice2=8'hA5 held -> gnt=4'b0100 one cycle after req, then q=8'hA5, q_valid=1, owner=2, done one cycle, gnt=0.
- Round robin: req=4'b1111 held continuously with slices 8'h10/11/12/13 -> grants in order 0,1,2,3,0 at 3-cycle spacing; q sequence 10,11,12,13,10; done pulses every 3rd cycle.
- Wrap priority: after requester 3 wins, req=4'b1001 -> requester 0 granted next; then requester 3.
- Abort: req=4'b0010, drop req[1] during the GRANT cycle -> abort pulse, done=0, q unchanged; next req=4'b0011 grants requester 0? No: pointer is 2, so scan 2,3,0 -> requester 0 granted.
- Clear: after q=8'h5A, assert clr in IDLE with req=4'b0001 -> q=0, q_valid=0, no gnt that cycle; with clr in GRANT -> gnt drops, q=0, no done, and the same requester wins again when re-requested.
- Async reset mid-GRANT: reset_n low during gnt=4'b1000 -> gnt, q, q_valid, done, abort all 0 immediately (before the next clk edge); pointer 0, so req=4'b1001 grants requester 0.
